// File: rtl/sramlike_sram_slave_pkg.sv
// sramlike_sram_slave_pkg: sram_like size encodings and byte-enable helper
package sramlike_sram_slave_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  // misaligned half/word accesses yield no enables
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    return size == SZ_BYTE ? 4'b0001 << a :
           size == SZ_HALF ? (a[0] ? 4'b0000 : a[1] ? 4'b1100 : 4'b0011) :
           (a != 2'b00 ? 4'b0000 : 4'b1111);
  endfunction
endpackage

// File: rtl/sramlike_resp_fifo.sv
// sramlike_resp_fifo: synchronous response FIFO with head-of-queue data
module sramlike_resp_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         empty,
  output logic         full,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]  wp_q, wp_d, rp_q, rp_d;
  logic [W-1:0] mem_q [DEPTH];
  always_comb begin
    empty = wp_q == rp_q;
    full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    head  = mem_q[rp_q[AW-1:0]];
    wp_d  = wp_q + (AW+1)'(push);
    rp_d  = rp_q + (AW+1)'(pop);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      if (push) mem_q[wp_q[AW-1:0]] <= din;
    end
  end
endmodule

// File: rtl/sramlike_sram_slave.sv
// sramlike_sram_slave: in-order sram_like responder backed by a synchronous SRAM
module sramlike_sram_slave
  import sramlike_sram_slave_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 2,
  parameter int LAT    = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = LAT > 0 ? $clog2(LAT + 1) : 1;
  logic [CW-1:0] out_q, out_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          s1_v_q, s1_v_d, s1_wr_q, s1_wr_d;
  logic          empty, full;
  logic [31:0]   head;
  always_comb begin
    addr_ok   = req && (out_q < CW'(DEPTH));
    ram_en    = addr_ok;
    ram_addr  = addr_ok ? addr[ADDR_W+1:2] : '0;
    ram_wdata = addr_ok ? wdata : '0;
    ram_we    = addr_ok && wr ? byte_en(size, addr[1:0]) : 4'b0000;
    data_ok   = !empty && cnt_q == '0;
    rdata     = data_ok ? head : '0;
    s1_v_d    = addr_ok;
    s1_wr_d   = addr_ok && wr;
    cnt_d     = (empty || data_ok) ? LW'(LAT) : cnt_q - LW'(cnt_q != '0);
    out_d     = out_q + CW'(addr_ok) - CW'(data_ok);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      out_q   <= '0;
      cnt_q   <= LW'(LAT);
      s1_v_q  <= 1'b0;
      s1_wr_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      s1_v_q  <= s1_v_d;
      s1_wr_q <= s1_wr_d;
    end
  end
  // outstanding count covers s1 too, so the FIFO always has room when s1 pushes
  sramlike_resp_fifo #(.W(32), .DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (s1_v_q && !full),
    .pop  (data_ok),
    .din  (s1_wr_q ? 32'h0 : ram_rdata),
    .empty(empty),
    .full (full),
    .head (head)
  );
endmodule

// File: tb/tb_sramlike_sram_slave.sv
// tb_sramlike_sram_slave: scoreboard bench for LAT=0 and LAT=3 responders
module tb_sramlike_sram_slave;
  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req [2];
  logic        wr [2];
  logic [1:0]  size [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        addr_ok [2];
  logic        data_ok [2];
  logic [31:0] rdata [2];
  logic        ram_en [2];
  logic [3:0]  ram_we [2];
  logic [15:0] ram_addr [2];
  logic [31:0] ram_wdata [2];
  logic [31:0] rd [2];
  logic [31:0] mem [2][256];
  exp_t        sb [2][$];
  exp_t        e;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : u
    sramlike_sram_slave #(.ADDR_W(16), .DEPTH(2), .LAT(g * 3)) dut (
      .clock    (clock),
      .reset    (reset),
      .req      (req[g]),
      .wr       (wr[g]),
      .size     (size[g]),
      .addr     (addr[g]),
      .wdata    (wdata[g]),
      .addr_ok  (addr_ok[g]),
      .data_ok  (data_ok[g]),
      .rdata    (rdata[g]),
      .ram_en   (ram_en[g]),
      .ram_we   (ram_we[g]),
      .ram_addr (ram_addr[g]),
      .ram_wdata(ram_wdata[g]),
      .ram_rdata(rd[g])
    );
    always @(posedge clock) begin
      if (ram_en[g]) begin
        for (int b = 0; b < 4; b++)
          if (ram_we[g][b]) mem[g][ram_addr[g][7:0]][8*b+:8] <= ram_wdata[g][8*b+:8];
        rd[g] <= mem[g][ram_addr[g][7:0]];
      end
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        if (data_ok[d]) begin
          if (sb[d].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_data_ok dut%0d at cycle %0d: got 1 expected 0", d, cyc);
          end else begin
            e = sb[d].pop_front();
            chk($sformatf("rdata_dut%0d", d), rdata[d], e.data);
            if (e.due >= 0) chk($sformatf("data_ok_cycle_dut%0d", d), cyc, e.due);
          end
        end else chk($sformatf("rdata_idle_dut%0d", d), rdata[d], 32'h0);
      end
    end
  end

  // enters and leaves 1 time unit after a rising edge
  task automatic issue(input int d, input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic [3:0] exp_we,
                       input int lat, input bit hold, output int t);
    exp_t x;
    int   k = 0;
    req[d] = 1'b1; wr[d] = w; size[d] = sz; addr[d] = a; wdata[d] = wd;
    t = -1;
    while (t < 0 && k < 50) begin
      @(negedge clock);
      if (addr_ok[d]) begin
        t = cyc;
        chk("ram_en", 32'(ram_en[d]), 32'h1);
        chk("ram_we", 32'(ram_we[d]), 32'(exp_we));
        chk("ram_addr", 32'(ram_addr[d]), 32'(a[17:2]));
        chk("ram_wdata", ram_wdata[d], wd);
        x.data = exp_rd;
        x.due  = lat < 0 ? -1 : cyc + lat;
        sb[d].push_back(x);
      end
      @(posedge clock);
      #1;
      k++;
    end
    if (t < 0) chk("addr_ok_timeout", 32'h0, 32'h1);
    if (!hold || t < 0) req[d] = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((sb[0].size() != 0 || sb[1].size() != 0) && k < 100) begin
      @(posedge clock);
      k++;
    end
    if (k == 100) chk("drain_timeout", 32'(sb[0].size() + sb[1].size()), 32'h0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int t, t0, t1, t2, t3;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; wr[d] = 1'b0; size[d] = 2'd0; addr[d] = 32'h0; wdata[d] = 32'h0;
      for (int i = 0; i < 256; i++) mem[d][i] <= 32'h0;
      for (int i = 0; i < 4; i++) mem[d][8'h80 + i] <= 32'hA0A0_0000 + 32'(i);
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk("rst_addr_ok", 32'(addr_ok[d]), 32'h0);
      chk("rst_data_ok", 32'(data_ok[d]), 32'h0);
      chk("rst_rdata", rdata[d], 32'h0);
      chk("rst_ram_en", 32'(ram_en[d]), 32'h0);
      chk("rst_ram_we", 32'(ram_we[d]), 32'h0);
      chk("rst_ram_addr", 32'(ram_addr[d]), 32'h0);
      chk("rst_ram_wdata", ram_wdata[d], 32'h0);
    end
    @(posedge clock);
    #1 reset = 1'b0;

    issue(0, 1'b0, 2'd2, 32'h0, 32'h0, 32'h0, 4'h0, 2, 1'b0, t);
    drain();
    issue(0, 1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 32'h0, 4'b1111, 2, 1'b0, t);
    issue(0, 1'b0, 2'd2, 32'h100, 32'h0, 32'hDEADBEEF, 4'b0000, 2, 1'b0, t);
    issue(0, 1'b1, 2'd0, 32'h101, 32'h0000AB00, 32'h0, 4'b0010, 2, 1'b0, t);
    issue(0, 1'b0, 2'd2, 32'h100, 32'h0, 32'hDEADABEF, 4'b0000, 2, 1'b0, t);
    issue(0, 1'b1, 2'd1, 32'h103, 32'hABCDABCD, 32'h0, 4'b0000, 2, 1'b0, t);
    issue(0, 1'b0, 2'd2, 32'h100, 32'h0, 32'hDEADABEF, 4'b0000, 2, 1'b0, t);
    issue(0, 1'b1, 2'd2, 32'h102, 32'h12345678, 32'h0, 4'b0000, 2, 1'b0, t);
    issue(0, 1'b1, 2'd1, 32'h102, 32'h55665566, 32'h0, 4'b1100, 2, 1'b0, t);
    issue(0, 1'b0, 2'd2, 32'h100, 32'h0, 32'h5566ABEF, 4'b0000, 2, 1'b0, t);
    drain();

    issue(0, 1'b0, 2'd2, 32'h200, 32'h0, 32'hA0A00000, 4'h0, 2, 1'b1, t0);
    issue(0, 1'b0, 2'd2, 32'h204, 32'h0, 32'hA0A00001, 4'h0, 2, 1'b1, t1);
    issue(0, 1'b0, 2'd2, 32'h208, 32'h0, 32'hA0A00002, 4'h0, 2, 1'b1, t2);
    issue(0, 1'b0, 2'd2, 32'h20C, 32'h0, 32'hA0A00003, 4'h0, 2, 1'b0, t3);
    chk("accept2_offset", 32'(t1 - t0), 32'd1);
    chk("accept3_offset", 32'(t2 - t0), 32'd3);
    chk("accept4_offset", 32'(t3 - t0), 32'd4);
    drain();

    issue(1, 1'b0, 2'd2, 32'h200, 32'h0, 32'hA0A00000, 4'h0, 5, 1'b0, t);
    drain();
    issue(1, 1'b0, 2'd2, 32'h204, 32'h0, 32'hA0A00001, 4'h0, 5, 1'b1, t0);
    issue(1, 1'b0, 2'd2, 32'h208, 32'h0, 32'hA0A00002, 4'h0, 8, 1'b0, t1);
    chk("lat3_accept2_offset", 32'(t1 - t0), 32'd1);
    drain();

    issue(0, 1'b0, 2'd2, 32'h200, 32'h0, 32'hA0A00000, 4'h0, -1, 1'b0, t);
    issue(0, 1'b0, 2'd2, 32'h204, 32'h0, 32'hA0A00001, 4'h0, -1, 1'b0, t);
    reset = 1'b1;
    sb[0].delete();
    sb[1].delete();
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    issue(0, 1'b0, 2'd2, 32'h0, 32'h0, 32'h0, 4'h0, 2, 1'b0, t);
    drain();
    chk("sb0_empty", 32'(sb[0].size()), 32'h0);
    chk("sb1_empty", 32'(sb[1].size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
